// File: rtl/dca_matrix_row_loader.sv
// dca_matrix_row_loader
//   Packs MATRIX_NUM_COL scalars from a valid/ready stream into one tensor row
//   and writes it into the DCA row-shifting matrix register with a one-cycle
//   move_wenable strobe. MATRIX_NUM_ROW row writes complete one matrix; one
//   matrix is loaded per start.
//
// Ports
//   clk             rising-edge clock
//   rstpp           asynchronous active-high reset
//   start           begin one matrix load (honoured only when idle)
//   clear           synchronous abort, highest priority
//   scalar_valid    input scalar valid
//   scalar_ready    loader accepts a scalar this cycle (decoded from state)
//   scalar_data     input scalar
//   move_wenable    registered row write strobe
//   move_wdata_list registered packed row, column c at [c*BW +: BW]
//   init            registered register-init pulse (INIT state only)
//   busy            load in progress (decoded from state)
//   done            registered pulse alongside the final row strobe
//
// Configuration
//   DCA_ROW_LOADER_INIT_EN : when defined, each start passes through a
//   one-cycle INIT state that pulses init; otherwise init is tied low.

module dca_matrix_row_loader #(
  parameter int unsigned MATRIX_NUM_ROW   = 8,
  parameter int unsigned MATRIX_NUM_COL   = 8,
  parameter int unsigned BW_TENSOR_SCALAR = 32
) (
  input  logic                                       clk,
  input  logic                                       rstpp,
  input  logic                                       start,
  input  logic                                       clear,
  input  logic                                       scalar_valid,
  output logic                                       scalar_ready,
  input  logic [BW_TENSOR_SCALAR-1:0]                scalar_data,
  output logic                                       move_wenable,
  output logic [MATRIX_NUM_COL*BW_TENSOR_SCALAR-1:0] move_wdata_list,
  output logic                                       init,
  output logic                                       busy,
  output logic                                       done
);

  localparam int unsigned BW_TENSOR_ROW = MATRIX_NUM_COL * BW_TENSOR_SCALAR;
  localparam int unsigned COL_W = (MATRIX_NUM_COL > 1) ? $clog2(MATRIX_NUM_COL) : 1;
  localparam int unsigned ROW_W = (MATRIX_NUM_ROW > 1) ? $clog2(MATRIX_NUM_ROW) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MATRIX_NUM_COL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MATRIX_NUM_ROW - 1);

`ifdef DCA_ROW_LOADER_INIT_EN
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_LOAD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD} state_t;
`endif

  state_t                   state_q, state_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [BW_TENSOR_ROW-1:0] buf_q, buf_d;
  logic [BW_TENSOR_ROW-1:0] wdata_q, wdata_d;
  logic                     wen_q, wen_d;
  logic                     done_q, done_d;
`ifdef DCA_ROW_LOADER_INIT_EN
  logic                     init_q, init_d;
`endif

  logic                     accept;
  logic [BW_TENSOR_ROW-1:0] row_merged;

  assign scalar_ready = (state_q == S_LOAD);
  assign busy         = (state_q != S_IDLE);
  assign accept       = scalar_valid & scalar_ready;

  // The last column never lands in the buffer: it is merged on the fly so the
  // buffer is free for the next row in the very next cycle.
  always_comb begin
    row_merged = buf_q;
    row_merged[(MATRIX_NUM_COL-1)*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] = scalar_data;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    buf_d   = buf_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    done_d  = 1'b0;
`ifdef DCA_ROW_LOADER_INIT_EN
    init_d  = 1'b0;
`endif
    if (clear) begin
      state_d = S_IDLE;
      col_d   = '0;
      row_d   = '0;
      buf_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            col_d = '0;
            row_d = '0;
`ifdef DCA_ROW_LOADER_INIT_EN
            state_d = S_INIT;
            init_d  = 1'b1;
`else
            state_d = S_LOAD;
`endif
          end
        end
`ifdef DCA_ROW_LOADER_INIT_EN
        S_INIT: state_d = S_LOAD;
`endif
        S_LOAD: begin
          if (accept) begin
            if (col_q == COL_LAST) begin
              wdata_d = row_merged;
              wen_d   = 1'b1;
              col_d   = '0;
              if (row_q == ROW_LAST) begin
                done_d  = 1'b1;
                row_d   = '0;
                state_d = S_IDLE;
              end else begin
                row_d = row_q + ROW_W'(1);
              end
            end else begin
              for (int unsigned c = 0; c < MATRIX_NUM_COL; c++) begin
                if (col_q == COL_W'(c)) begin
                  buf_d[c*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] = scalar_data;
                end
              end
              col_d = col_q + COL_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstpp) begin
    if (rstpp) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      buf_q   <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef DCA_ROW_LOADER_INIT_EN
      init_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
`ifdef DCA_ROW_LOADER_INIT_EN
      init_q  <= init_d;
`endif
    end
  end

  assign move_wenable    = wen_q;
  assign move_wdata_list = wdata_q;
  assign done            = done_q;
`ifdef DCA_ROW_LOADER_INIT_EN
  assign init            = init_q;
`else
  assign init            = 1'b0;
`endif

endmodule

// File: tb/tb_dca_matrix_row_loader.sv
// Testbench for dca_matrix_row_loader: 4x4 matrix of 16-bit scalars,
// directed vectors with hand-computed expected rows.
`timescale 1ns/1ps
module tb_dca_matrix_row_loader;

  localparam int unsigned NR  = 4;
  localparam int unsigned NC  = 4;
  localparam int unsigned BW  = 16;
  localparam int unsigned BWR = NC * BW;

  logic           clk = 1'b0;
  logic           rstpp;
  logic           start;
  logic           clear;
  logic           scalar_valid;
  logic           scalar_ready;
  logic [BW-1:0]  scalar_data;
  logic           move_wenable;
  logic [BWR-1:0] move_wdata_list;
  logic           init;
  logic           busy;
  logic           done;

  int vectors     = 0;
  int miscompares = 0;

  logic [BWR-1:0] exp_rows [NR];

  always #5 clk = ~clk;

  dca_matrix_row_loader #(
    .MATRIX_NUM_ROW  (NR),
    .MATRIX_NUM_COL  (NC),
    .BW_TENSOR_SCALAR(BW)
  ) dut (
    .clk            (clk),
    .rstpp          (rstpp),
    .start          (start),
    .clear          (clear),
    .scalar_valid   (scalar_valid),
    .scalar_ready   (scalar_ready),
    .scalar_data    (scalar_data),
    .move_wenable   (move_wenable),
    .move_wdata_list(move_wdata_list),
    .init           (init),
    .busy           (busy),
    .done           (done)
  );

  // Advance one cycle; outputs are then sampled and inputs changed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: push n scalars base..base+n-1 at full rate, counting strobes.
  task automatic feed(input int n, input int base, output int wens, output int dones);
    wens  = 0;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      scalar_valid = 1'b1;
      scalar_data  = BW'(base + i);
      step();
      if (move_wenable === 1'b1) wens++;
      if (done === 1'b1) dones++;
    end
    scalar_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef DCA_ROW_LOADER_INIT_EN
    step();
`endif
  endtask

  task automatic test_reset();
    rstpp = 1'b1; start = 1'b0; clear = 1'b0; scalar_valid = 1'b0; scalar_data = '0;
    step(); step();
    vectors++;
    if ({scalar_ready, move_wenable, init, busy, done} !== 5'b0 || move_wdata_list !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b wen=%b init=%b busy=%b done=%b wdata=%h, need all 0",
               scalar_ready, move_wenable, init, busy, done, move_wdata_list);
    end
    rstpp = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0 || scalar_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got busy=%b rdy=%b, need 0 0", busy, scalar_ready);
    end
  endtask

  task automatic test_stream(input bit toggle, input int gap, input string name);
    int n_acc, n_wen, cyc, last_cyc;
    bit acc;
    n_acc = 0; n_wen = 0; cyc = 0; last_cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef DCA_ROW_LOADER_INIT_EN
    vectors++;
    if (init !== 1'b1 || scalar_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s init_cycle: got init=%b rdy=%b, need init=1 rdy=0", name, init, scalar_ready);
    end
    step();
`endif
    vectors++;
    if (scalar_ready !== 1'b1 || busy !== 1'b1 || init !== 1'b0) begin
      miscompares++;
      $display("FAIL %s load_entry: got rdy=%b busy=%b init=%b, need 1 1 0", name, scalar_ready, busy, init);
    end
    while (n_wen < NR && cyc < 200) begin
      scalar_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      scalar_data  = BW'(n_acc + 1);
      acc = scalar_valid & scalar_ready;
      step();
      cyc++;
      if (acc) n_acc++;
      if (move_wenable === 1'b1) begin
        vectors++;
        if (move_wdata_list !== exp_rows[n_wen]) begin
          miscompares++;
          $display("FAIL %s row%0d_data: got %h, need %h", name, n_wen, move_wdata_list, exp_rows[n_wen]);
        end
        if (n_wen > 0) begin
          vectors++;
          if (cyc - last_cyc != gap) begin
            miscompares++;
            $display("FAIL %s row%0d_gap: got %0d cycles, need %0d", name, n_wen, cyc - last_cyc, gap);
          end
        end
        vectors++;
        if (done !== (n_wen == NR - 1)) begin
          miscompares++;
          $display("FAIL %s row%0d_done: got %b, need %b", name, n_wen, done, n_wen == NR - 1);
        end
        last_cyc = cyc;
        n_wen++;
      end else if (done !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL %s stray_done: got 1 at cycle %0d without strobe, need 0", name, cyc);
      end
    end
    scalar_valid = 1'b0;
    vectors++;
    if (n_wen != NR) begin
      miscompares++;
      $display("FAIL %s strobe_count: got %0d strobes in budget, need %0d", name, n_wen, NR);
    end
    vectors++;
    if (n_acc != NR * NC) begin
      miscompares++;
      $display("FAIL %s accept_count: got %0d, need %0d", name, n_acc, NR * NC);
    end
    vectors++;
    if (busy !== 1'b0 || scalar_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_after_done: got busy=%b rdy=%b, need 0 0", name, busy, scalar_ready);
    end
    repeat (5) begin
      step();
      vectors++;
      if (move_wenable !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s quiet_after_done: got wen=%b done=%b, need 0 0", name, move_wenable, done);
      end
    end
  endtask

  task automatic test_clear();
    int w, d;
    do_start();
    feed(6, 1, w, d);
    vectors++;
    if (w != 1 || d != 0) begin
      miscompares++;
      $display("FAIL clear_pre_strobes: got wen=%0d done=%0d, need 1 0", w, d);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    vectors++;
    if (busy !== 1'b0 || scalar_ready !== 1'b0 || move_wenable !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_idle: got busy=%b rdy=%b wen=%b, need 0 0 0", busy, scalar_ready, move_wenable);
    end
    repeat (6) begin
      step();
      vectors++;
      if (move_wenable !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_quiet: got wen=%b done=%b, need 0 0", move_wenable, done);
      end
    end
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_beats_start: got busy=%b, need 0", busy);
    end
    do_start();
    feed(4, 'h101, w, d);
    vectors++;
    if (w != 1 || move_wenable !== 1'b1 || move_wdata_list !== 64'h0104_0103_0102_0101) begin
      miscompares++;
      $display("FAIL clear_restart_row0: got wens=%0d wen=%b data=%h, need 1 1 0104010301020101",
               w, move_wenable, move_wdata_list);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_start_ignored();
    int w, d;
    do_start();
    feed(2, 1, w, d);
    start        = 1'b1;
    scalar_valid = 1'b1;
    scalar_data  = BW'(3);
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || init !== 1'b0) begin
      miscompares++;
      $display("FAIL start_busy_ignored: got busy=%b init=%b, need 1 0", busy, init);
    end
    feed(1, 4, w, d);
    vectors++;
    if (w != 1 || move_wdata_list !== exp_rows[0]) begin
      miscompares++;
      $display("FAIL start_busy_row0: got wens=%0d data=%h, need 1 %h", w, move_wdata_list, exp_rows[0]);
    end
    feed(12, 5, w, d);
    vectors++;
    if (w != 3 || d != 1 || move_wdata_list !== exp_rows[3] || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_busy_finish: got wens=%0d dones=%0d data=%h busy=%b, need 3 1 %h 0",
               w, d, move_wdata_list, busy, exp_rows[3]);
    end
    step();
  endtask

  task automatic test_reset_midload();
    int w, d;
    do_start();
    feed(5, 1, w, d);
    vectors++;
    if (w != 1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_state: got wens=%0d busy=%b, need 1 1", w, busy);
    end
    feed(1, 6, w, d);
    #1 rstpp = 1'b1;
    #1;
    vectors++;
    if ({scalar_ready, move_wenable, init, busy, done} !== 5'b0 || move_wdata_list !== '0) begin
      miscompares++;
      $display("FAIL rst_async: got rdy=%b wen=%b init=%b busy=%b done=%b wdata=%h, need all 0",
               scalar_ready, move_wenable, init, busy, done, move_wdata_list);
    end
    step();
    rstpp        = 1'b0;
    scalar_valid = 1'b1;
    scalar_data  = BW'(7);
    repeat (8) begin
      step();
      vectors++;
      if (move_wenable !== 1'b0 || scalar_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_after_release: got wen=%b rdy=%b busy=%b done=%b, need 0 0 0 0",
                 move_wenable, scalar_ready, busy, done);
      end
    end
    scalar_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_rows[0] = 64'h0004_0003_0002_0001;
    exp_rows[1] = 64'h0008_0007_0006_0005;
    exp_rows[2] = 64'h000C_000B_000A_0009;
    exp_rows[3] = 64'h0010_000F_000E_000D;
    test_reset();
    test_stream(1'b0, 4, "full_rate");
    test_stream(1'b1, 8, "toggle_valid");
    test_clear();
    test_start_ignored();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
